// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath select codes and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemadr = 4'd2;
  localparam logic [3:0] StMemrd  = 4'd3;
  localparam logic [3:0] StMemwb  = 4'd4;
  localparam logic [3:0] StMemwr  = 4'd5;
  localparam logic [3:0] StRex    = 4'd6;
  localparam logic [3:0] StRwb    = 4'd7;
  localparam logic [3:0] StBeqex  = 4'd8;
  localparam logic [3:0] StImmex  = 4'd9;
  localparam logic [3:0] StImmwb  = 4'd10;
  localparam logic [3:0] StJex    = 4'd11;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OpAddi) || (op == OpSlti) || (op == OpAndi) ||
           (op == OpOri)  || (op == OpXori) || (op == OpLui);
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri) || (op == OpXori);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational Moore decode of the control FSM state into datapath controls.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.alu_src_b = SrcBFour;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: ctrl.alu_src_b = SrcBImmSh2;
      StMemadr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemrd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemwb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemwr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StRex: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StRwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBeqex: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
      end
      StImmex: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluImm;
      end
      StImmwb: ctrl.reg_write = 1'b1;
      StJex: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequencing, immediate
// extension mode and illegal-opcode flag.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               extend_sign,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               extend_sign_q, illegal_op_q;
  logic               op_legal;
  ctrl_t              ctrl_raw, ctrl;

  assign op_legal = (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
                    (op == OpBeq) || (op == OpJ) || is_imm_op(op);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = STATE_W'(StDecode);
      StDecode: begin
        if ((op == OpLw) || (op == OpSw)) state_d = STATE_W'(StMemadr);
        else if (op == OpRtype)           state_d = STATE_W'(StRex);
        else if (op == OpBeq)             state_d = STATE_W'(StBeqex);
        else if (op == OpJ)               state_d = STATE_W'(StJex);
        else if (is_imm_op(op))           state_d = STATE_W'(StImmex);
        else                              state_d = STATE_W'(StFetch);
      end
      StMemadr: state_d = (op == OpLw) ? STATE_W'(StMemrd) : STATE_W'(StMemwr);
      StMemrd:  if (mem_ready) state_d = STATE_W'(StMemwb);
      StMemwr:  if (mem_ready) state_d = STATE_W'(StFetch);
      StRex:    state_d = STATE_W'(StRwb);
      StImmex:  state_d = STATE_W'(StImmwb);
      default:  state_d = STATE_W'(StFetch);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= STATE_W'(StFetch);
      extend_sign_q <= 1'b1;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= (state_q == STATE_W'(StDecode)) && !op_legal;
      if (state_q == STATE_W'(StDecode)) extend_sign_q <= !is_zext_op(op);
    end
  end

  ctrl_out_decode #(
    .STATE_W (STATE_W)
  ) u_ctrl_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Reset parks the FSM in FETCH, whose decode requests memory; mask it so
  // nothing is requested or written while reset is held.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign extend_sign   = extend_sign_q;
  assign illegal_op    = illegal_op_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level reference
// model (per-opcode state paths, stall rules and cycle budgets).
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, extend_sign, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [15:0] ctrl_vec;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .extend_sign   (extend_sign),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [3:0] path[$];
  logic [5:0] dir_ops[$];
  int         idx, stalls, dut_cycles;
  bit         fresh;
  logic       exp_ext, exp_ill;
  logic [3:0] prev_state;

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                     6'h0E, 6'h0F};
  endfunction

  function automatic int exp_len(input logic [5:0] o);
    if (o == 6'h23) return 5;
    if (o inside {6'h2B, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return 4;
    if (o inside {6'h04, 6'h02}) return 3;
    return 2;
  endfunction

  function automatic void build_path(input logic [5:0] o);
    path = {StFetch, StDecode};
    case (o)
      6'h23: begin path.push_back(StMemadr); path.push_back(StMemrd); path.push_back(StMemwb); end
      6'h2B: begin path.push_back(StMemadr); path.push_back(StMemwr); end
      6'h00: begin path.push_back(StRex); path.push_back(StRwb); end
      6'h04: path.push_back(StBeqex);
      6'h02: path.push_back(StJex);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        path.push_back(StImmex); path.push_back(StImmwb);
      end
      default: ;
    endcase
  endfunction

  // Control word expected in each state, straight from the output table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
    {sb, ao, ps} = '0;
    case (s)
      StFetch:  begin mrd = 1; irw = mr; sb = 2'b01; pw = mr; end
      StDecode: sb = 2'b11;
      StMemadr: begin sa = 1; sb = 2'b10; end
      StMemrd:  begin mrd = 1; iod = 1; end
      StMemwb:  begin rw = 1; m2r = 1; end
      StMemwr:  begin mwr = 1; iod = 1; end
      StRex:    begin sa = 1; ao = 2'b10; end
      StRwb:    begin rw = 1; rdst = 1; end
      StBeqex:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      StImmex:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
      StImmwb:  rw = 1;
      StJex:    begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0A, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F};
    logic [5:0] o;
    if ($urandom_range(0, 9) != 0) return ops[$urandom_range(0, 10)];
    do o = 6'($urandom_range(0, 63)); while (legal(o));
    return o;
  endfunction

  task automatic step_cycle(input bit rnd, input bit hold_mw);
    logic [3:0] cur;
    bit waits;
    @(negedge clk);
    if (fresh) begin
      if (dir_ops.size() > 0) op = dir_ops.pop_front();
      else op = pick_op();
      build_path(op);
      idx = 0; stalls = 0; fresh = 0;
    end
    cur = path[idx];
    if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
    else if (hold_mw && cur == StMemwr) mem_ready = 1'b0;
    else mem_ready = !(op == OpSw && cur == StMemwr && stalls < 3);
    #1;
    if (state == StFetch && prev_state != StFetch) dut_cycles = 0;
    dut_cycles++;
    prev_state = state;
    check("state", 32'(state), 32'(cur));
    check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(cur, mem_ready)));
    check("extend_sign", 32'(extend_sign), 32'(exp_ext));
    check("illegal_op", 32'(illegal_op), 32'(exp_ill));
    exp_ill = 1'b0;
    if (cur == StDecode) begin
      exp_ext = !(op inside {6'h0C, 6'h0D, 6'h0E});
      exp_ill = !legal(op);
    end
    waits = (cur inside {StFetch, StMemrd, StMemwr}) && !mem_ready;
    if (waits) stalls++;
    else begin
      idx++;
      if (idx == path.size()) begin
        check("length", 32'(dut_cycles), 32'(exp_len(op) + stalls));
        fresh = 1;
      end
    end
  endtask

  // Run instruction o until it sits in target, then pulse reset there.
  task automatic reset_at(input logic [5:0] o, input logic [3:0] target);
    int guard;
    guard = 0;
    while (!fresh && guard < 20) begin step_cycle(0, 0); guard++; end
    dir_ops.push_back(o);
    step_cycle(0, 1);
    guard = 0;
    while (!(!fresh && path[idx] == target) && guard < 20) begin step_cycle(0, 1); guard++; end
    check("reach_target", 32'(!fresh && path[idx] == target), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("pre_rst_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(target, 1'b0)));
    check("pre_rst_ext", 32'(extend_sign), 32'(exp_ext));
    reset = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    check("rst_state", 32'(state), 32'(StFetch));
    check("rst_ext", 32'(extend_sign), 32'd1);
    check("rst_ill", 32'(illegal_op), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_state", 32'(state), 32'(StFetch));
    check("post_rst_ext", 32'(extend_sign), 32'd1);
    fresh = 1; exp_ext = 1'b1; exp_ill = 1'b0; prev_state = 4'hF;
  endtask

  initial begin
    int guard;
    reset = 1'b1; op = 6'h00; mem_ready = 1'b1;
    fresh = 1; exp_ext = 1'b1; exp_ill = 1'b0; prev_state = 4'hF;
    idx = 0; stalls = 0; dut_cycles = 0;
    #12;
    check("init_ctrl", 32'(ctrl_vec), 32'd0);
    check("init_state", 32'(state), 32'(StFetch));
    check("init_ext", 32'(extend_sign), 32'd1);
    check("init_ill", 32'(illegal_op), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;

    dir_ops = {OpLw, OpOri, OpAddi, OpSw, 6'h3F, OpBeq, OpJ};
    guard = 0;
    while (!(dir_ops.size() == 0 && fresh) && guard < 200) begin step_cycle(0, 0); guard++; end
    check("directed_done", 32'(dir_ops.size() == 0 && fresh), 32'd1);

    repeat (600) step_cycle(1, 0);

    reset_at(OpSw, StMemwr);
    reset_at(OpOri, StImmwb);
    repeat (300) step_cycle(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for the supported instruction subset. It drives every datapath enable and mux select, including the immediate extender's `ExtendSign` mode input. It stalls on a memory ready handshake.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register (12 states used).

Ports:
- `clk`  input  1  single system clock, rising edge.
- `reset`  input  1  asynchronous, active-high. State and registered outputs clear immediately.
- `op`  input  6  IR[31:26], valid from DECODE onward.
- `mem_ready`  input  1  memory completes the access this cycle.
- `pc_write`  output  1  unconditional PC load.
- `pc_write_cond`  output  1  PC load if ALU zero (beq).
- `i_or_d`  output  1  address mux: 0 = PC, 1 = ALUOut.
- `mem_read`  output  1  memory read request.
- `mem_write`  output  1  memory write request.
- `ir_write`  output  1  instruction register load.
- `mem_to_reg`  output  1  writeback source: 1 = MDR.
- `reg_dst`  output  1  destination register: 1 = rd, 0 = rt.
- `reg_write`  output  1  register file write.
- `alu_src_a`  output  1  0 = PC, 1 = A.
- `alu_src_b`  output  2  00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate shifted left 2.
- `alu_op`  output  2  00 = add, 01 = sub, 10 = funct, 11 = immediate-op.
- `pc_source`  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `extend_sign`  output  1  connects to the extender's `ExtendSign`. 1 = sign-extend, 0 = zero-extend.
- `illegal_op`  output  1  one-cycle pulse on an unsupported opcode.
- `state`  output  `STATE_W`  current state, for debug.

## Operation
- Opcodes:
  - R-type: 0x00
  - lw: 0x23
  - sw: 0x2B
  - beq: 0x04
  - j: 0x02
  - addi: 0x08
  - slti: 0x0A
  - andi: 0x0C
  - ori: 0x0D
  - xori: 0x0E
  - lui: 0x0F
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQEX, IMMEX, IMMWB, JEX.
- Transitions:
  - FETCH → DECODE when `mem_ready`. Otherwise stay in FETCH.
  - DECODE dispatches by opcode:
    - lw/sw → MEMADR
    - R-type → REX
    - beq → BEQEX
    - j → JEX
    - addi/slti/andi/ori/xori/lui → IMMEX
    - anything else → FETCH, with `illegal_op` = 1 for that cycle
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB when `mem_ready`. MEMWB → FETCH.
  - MEMWR → FETCH when `mem_ready`.
  - REX → RWB → FETCH.
  - IMMEX → IMMWB → FETCH.
  - BEQEX → FETCH. JEX → FETCH.
- Outputs are Moore, decoded from state. Every signal not listed for a state is 0.
  - FETCH: mem_read, ir_write (qualified by mem_ready), alu_src_b = 01, pc_write (qualified by mem_ready).
  - DECODE: alu_src_b = 11.
  - MEMADR: alu_src_a, alu_src_b = 10.
  - MEMRD: mem_read, i_or_d.
  - MEMWB: reg_write, mem_to_reg.
  - MEMWR: mem_write, i_or_d.
  - REX: alu_src_a, alu_op = 10.
  - RWB: reg_write, reg_dst.
  - BEQEX: alu_src_a, alu_op = 01, pc_write_cond, pc_source = 01.
  - IMMEX: alu_src_a, alu_src_b = 10, alu_op = 11.
  - IMMWB: reg_write.
  - JEX: pc_write, pc_source = 10.
- `extend_sign` is a register:
  - Loaded in DECODE: 0 if `op` is andi, ori or xori, else 1.
  - Held until the next DECODE.
  - Reset value 1.

## Timing
- State register resets asynchronously to FETCH.
- While `reset` is high, all write and request outputs are forced to 0: `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`.
- Other outputs reset to 0, except `extend_sign` (1) and `state` (FETCH).
- `illegal_op` resets to 0 and is registered: it is high in the cycle after DECODE, coinciding with the return to FETCH.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5
  - sw, R-type, immediate ops: 4
  - beq, j: 3
- Each cycle of low `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_read`/`mem_write` stay asserted and stable until the access completes.
- `extend_sign` is stable from the cycle after DECODE through writeback, so it is valid in MEMADR, IMMEX and BEQEX.
- Reset mid-instruction aborts with no `reg_write` or `mem_write` pulse. The first post-reset edge starts FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants
  - state encoding
  - `alu_op`, `alu_src_b` and `pc_source` codes
- One sub-module, `ctrl_out_decode`: a purely combinational state-to-output decode.
- The FSM, the `extend_sign` register and the `illegal_op` register stay in `multicycle_ctrl`.

## Test plan
- Reset asserted mid-MEMWR → `mem_write` drops to 0 immediately. After release, `state` = FETCH and `extend_sign` = 1.
- lw (op 0x23) with `mem_ready` = 1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `reg_write` = 1 and `mem_to_reg` = 1 only in cycle 5.
- ori (0x0D) then addi (0x08) → `extend_sign` = 0 during the ori's IMMEX and IMMWB, and = 1 during the addi's.
- sw with `mem_ready` low for 3 cycles in MEMWR → instruction takes 7 cycles, with `mem_write` and `i_or_d` high throughout MEMWR.
- Opcode 0x3F → `illegal_op` pulses for exactly 1 cycle, FETCH follows DECODE, and no write enable is asserted.
- beq then j → each takes 3 cycles. BEQEX drives `pc_write_cond` = 1 with `pc_source` = 01. JEX drives `pc_write` = 1 with `pc_source` = 10.
